// File: rtl/bt656_encoder.sv
// BT.656 transmitter: emits EAV/SAV timing codes, blanking fill and active video
// for a 525-line frame. Active bytes come from an 8-bit source through valid/ready.
module bt656_encoder #(
  parameter int unsigned ACTIVE_WORDS   = 1440,
  parameter int unsigned HBLANK_WORDS   = 268,
  parameter int unsigned LINE_COUNT     = 525,
  parameter int unsigned F1_FIRST_LINE  = 266,
  parameter int unsigned V_BLANK1_END   = 19,
  parameter int unsigned V_BLANK2_FIRST = 264,
  parameter int unsigned V_BLANK2_LAST  = 282
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_pixel_in,
  input  logic       i_pixel_valid,
  output logic       o_pixel_ready,
  output logic [9:0] o_bt_656,
  output logic       o_h,
  output logic       o_v,
  output logic       o_f,
  output logic [9:0] o_line_number,
  output logic       o_frame_start,
  output logic       o_underflow
);

  localparam int unsigned LINE_WORDS = 8 + HBLANK_WORDS + ACTIVE_WORDS;
  localparam int unsigned WW         = $clog2(LINE_WORDS);
  // Field 0 always starts on line 4 in 525-line timing.
  localparam int unsigned F0_FIRST_LINE = 4;

  localparam logic [WW-1:0] WordLast  = WW'(LINE_WORDS - 1);
  localparam logic [WW-1:0] EavXyWord = WW'(3);
  localparam logic [WW-1:0] SavWord   = WW'(4 + HBLANK_WORDS);
  localparam logic [WW-1:0] SavXyWord = WW'(4 + HBLANK_WORDS + 3);
  localparam logic [WW-1:0] ActWord   = WW'(8 + HBLANK_WORDS);

  localparam logic [9:0] LineLast = 10'(LINE_COUNT);
  localparam logic [9:0] F1Line   = 10'(F1_FIRST_LINE);
  localparam logic [9:0] F0Line   = 10'(F0_FIRST_LINE);
  localparam logic [9:0] Vb1End   = 10'(V_BLANK1_END);
  localparam logic [9:0] Vb2First = 10'(V_BLANK2_FIRST);
  localparam logic [9:0] Vb2Last  = 10'(V_BLANK2_LAST);

  logic [WW-1:0] r_word;
  logic [9:0]    r_line;
  logic [9:0]    r_bt_656;
  logic          r_h;
  logic          r_v;
  logic          r_f;
  logic [9:0]    r_line_number;
  logic          r_frame_start;
  logic          r_underflow;

  logic          w_f;
  logic          w_v;
  logic          w_in_hblank;
  logic          w_in_active;
  logic [7:0]    w_fill;
  logic [7:0]    w_byte;
  logic          w_underrun;

  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Line and word-region decode from the counter state.
  always_comb begin
    w_f         = (r_line >= F1Line) || (r_line < F0Line);
    w_v         = (r_line <= Vb1End) || ((r_line >= Vb2First) && (r_line <= Vb2Last));
    w_in_hblank = r_word < SavWord;
    w_in_active = r_word >= ActWord;
    w_fill      = r_word[0] ? 8'h10 : 8'h80;
  end

  // Hold ready low while reset is high so no pixel is taken by an aborted line.
  assign o_pixel_ready = w_in_active && !w_v && !i_reset;

  // Select the byte for the current word index.
  always_comb begin
    w_byte     = w_fill;
    w_underrun = 1'b0;
    if (r_word < SavWord && r_word <= EavXyWord) begin
      if (r_word == '0)             w_byte = 8'hFF;
      else if (r_word == EavXyWord) w_byte = xy_code(w_f, w_v, 1'b1);
      else                          w_byte = 8'h00;
    end else if (w_in_hblank) begin
      w_byte = w_fill;
    end else if (!w_in_active) begin
      if (r_word == SavWord)        w_byte = 8'hFF;
      else if (r_word == SavXyWord) w_byte = xy_code(w_f, w_v, 1'b0);
      else                          w_byte = 8'h00;
    end else if (!w_v) begin
      if (i_pixel_valid) begin
        // Keep 0x00/0xFF reserved for timing references.
        if (i_pixel_in == 8'h00)      w_byte = 8'h01;
        else if (i_pixel_in == 8'hFF) w_byte = 8'hFE;
        else                          w_byte = i_pixel_in;
      end else begin
        w_underrun = 1'b1;
      end
    end
  end

  // Counters and registered outputs; outputs lag the counters by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word        <= '0;
      r_line        <= 10'd1;
      r_bt_656      <= '0;
      r_h           <= 1'b0;
      r_v           <= 1'b0;
      r_f           <= 1'b0;
      r_line_number <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_bt_656      <= {w_byte, 2'b00};
      r_h           <= w_in_hblank;
      r_v           <= w_v;
      r_f           <= w_f;
      r_line_number <= r_line;
      r_frame_start <= (r_word == '0) && (r_line == 10'd1);
      r_underflow   <= r_underflow | w_underrun;
      if (r_word == WordLast) begin
        r_word <= '0;
        r_line <= (r_line == LineLast) ? 10'd1 : r_line + 10'd1;
      end else begin
        r_word <= r_word + 1'b1;
      end
    end
  end

  assign o_bt_656      = r_bt_656;
  assign o_h           = r_h;
  assign o_v           = r_v;
  assign o_f           = r_f;
  assign o_line_number = r_line_number;
  assign o_frame_start = r_frame_start;
  assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_bt656_encoder.sv
// Randomized bench for bt656_encoder with a short line (same 525-line vertical timing)
// so full frames fit in a short run. Expectations come from absolute time since reset.
module tb_bt656_encoder;

  localparam int AW    = 32;
  localparam int HB    = 12;
  localparam int LC    = 525;
  localparam int LL    = 8 + HB + AW;
  localparam int FRAME = LL * LC;
  localparam int SAV   = 4 + HB;
  localparam int ACT   = 8 + HB;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_pixel_in = 8'h00;
  logic       i_pixel_valid = 1'b0;
  logic       o_pixel_ready;
  logic [9:0] o_bt_656;
  logic       o_h, o_v, o_f;
  logic [9:0] o_line_number;
  logic       o_frame_start;
  logic       o_underflow;

  always #5 clk = ~clk;

  bt656_encoder #(
    .ACTIVE_WORDS  (AW),
    .HBLANK_WORDS  (HB),
    .LINE_COUNT    (LC),
    .F1_FIRST_LINE (266),
    .V_BLANK1_END  (19),
    .V_BLANK2_FIRST(264),
    .V_BLANK2_LAST (282)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_pixel_in   (i_pixel_in),
    .i_pixel_valid(i_pixel_valid),
    .o_pixel_ready(o_pixel_ready),
    .o_bt_656     (o_bt_656),
    .o_h          (o_h),
    .o_v          (o_v),
    .o_f          (o_f),
    .o_line_number(o_line_number),
    .o_frame_start(o_frame_start),
    .o_underflow  (o_underflow)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;   // cycles since reset release, in the model's time base
  int cyc     = 0;
  int xfers   = 0;
  bit chk_en  = 1'b0;
  int fs_cyc[$];

  logic [9:0] e_bt, e_line;
  bit e_h, e_v, e_f, e_fs, e_uf;
  int e_t = -1;
  logic [9:0] eav_l1 [4];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit f_of(int ln);
    return (ln >= 266) || (ln <= 3);
  endfunction

  function automatic bit v_of(int ln);
    return (ln <= 19) || (ln >= 264 && ln <= 282);
  endfunction

  function automatic logic [7:0] xy(bit f, bit v, bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [7:0] model_byte(int w, int ln, bit vld, logic [7:0] px);
    bit f = f_of(ln);
    bit v = v_of(ln);
    logic [7:0] fill = (w % 2 == 0) ? 8'h80 : 8'h10;
    if (w < 4)   return (w == 0) ? 8'hFF : (w == 3) ? xy(f, v, 1'b1) : 8'h00;
    if (w < SAV) return fill;
    if (w < ACT) return (w == SAV) ? 8'hFF : (w == SAV + 3) ? xy(f, v, 1'b0) : 8'h00;
    if (v || !vld) return fill;
    if (px == 8'h00) return 8'h01;
    if (px == 8'hFF) return 8'hFE;
    return px;
  endfunction

  task automatic check_outputs();
    if (!chk_en) return;
    check_eq("bt_656", o_bt_656, e_bt);
    check_eq("H", o_h, e_h);
    check_eq("V", o_v, e_v);
    check_eq("F", o_f, e_f);
    check_eq("line_number", o_line_number, e_line);
    check_eq("frame_start", o_frame_start, e_fs);
    check_eq("underflow", o_underflow, e_uf);
    // Fixed code words from the timing tables, independent of the model.
    if (e_t >= 0 && e_t < 4)         check_eq("l1_eav", o_bt_656, eav_l1[e_t]);
    if (e_t == SAV + 3)              check_eq("l1_sav_xy", o_bt_656, 10'h3B0);
    if (e_t == 19 * LL + 3)          check_eq("l20_eav_xy", o_bt_656, 10'h274);
    if (e_t == 19 * LL + SAV + 3)    check_eq("l20_sav_xy", o_bt_656, 10'h200);
    if (e_t == 282 * LL + SAV + 3)   check_eq("l283_sav_xy", o_bt_656, 10'h31C);
    if (o_frame_start === 1'b1) fs_cyc.push_back(cyc);
  endtask

  // One clock: check last edge's outputs, drive inputs, predict next edge's outputs.
  task automatic do_cycle(input bit rst, input bit vld, input logic [7:0] px);
    int w, ln;
    bit rdy;
    check_outputs();
    i_reset = rst;
    i_pixel_valid = vld;
    i_pixel_in = px;
    #1;
    w   = t % LL;
    ln  = (t / LL) % LC + 1;
    rdy = !rst && (w >= ACT) && !v_of(ln);
    check_eq("pixel_ready", o_pixel_ready, rdy);
    if (rst) begin
      e_bt = '0; e_h = 0; e_v = 0; e_f = 0; e_line = '0; e_fs = 0; e_uf = 0;
      e_t = -1;
      t = 0;
    end else begin
      e_bt   = {model_byte(w, ln, vld, px), 2'b00};
      e_h    = (w < SAV);
      e_v    = v_of(ln);
      e_f    = f_of(ln);
      e_line = 10'(ln);
      e_fs   = (t % FRAME == 0);
      if (rdy && vld)  xfers++;
      if (rdy && !vld) e_uf = 1;
      e_t = t;
      t++;
    end
    chk_en = 1'b1;
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [7:0] rand_px();
    logic [7:0] p = 8'($urandom);
    if ($urandom_range(7) == 0) p = ($urandom_range(1) == 1) ? 8'hFF : 8'h00;
    return p;
  endfunction

  initial begin
    bit hit;
    eav_l1[0] = 10'h3FC; eav_l1[1] = 10'h000; eav_l1[2] = 10'h000; eav_l1[3] = 10'h3C4;
    @(negedge clk);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 8'h00);

    // Full frame with valid held high: every ready cycle transfers.
    xfers = 0;
    fs_cyc.delete();
    for (int i = 0; i < FRAME + 4; i++) do_cycle(1'b0, 1'b1, rand_px());
    check_eq("xfers_frame", xfers, 487 * AW);
    if (fs_cyc.size() >= 2) check_eq("frame_period", fs_cyc[1] - fs_cyc[0], FRAME);
    else                    check_eq("frame_pulses", fs_cyc.size(), 2);

    // Sparse valid up to line 100 word 30 of the next frame, then reset mid-line.
    hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      if (t % FRAME == 99 * LL + 30) hit = 1;
      else do_cycle(1'b0, $urandom_range(99) < 85, rand_px());
    end
    check_eq("reach_l100", hit, 1);
    check_eq("underflow_seen", o_underflow, 1);
    do_cycle(1'b1, 1'b1, 8'h55);
    do_cycle(1'b1, 1'b1, 8'h55);

    for (int i = 0; i < 20000; i++) do_cycle(1'b0, $urandom_range(99) < 90, rand_px());
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
